// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for a short in-order pipeline. A tag
// pipeline (OP -> EX -> DM) shadows the datapath, recording for every slot
// whether it holds an instruction, which register it writes and whether the
// result only appears at the DM stage (loads). From those tags the block:
//   - chooses the forwarding source of each operand of the issuing instruction,
//   - stalls one cycle on a load-use dependency,
//   - kills the OP and EX slots on a flush,
//   - drives the register-file write port for the DM-stage instruction,
//   - counts load-use stall cycles (saturating).
//
// Handshake: the decode stage offers an instruction with in_valid. It is
// taken at the rising edge where in_valid && in_ready; in_ready is low only
// during a load-use stall and does not depend on flush or rst. An instruction
// presented while flush or rst is high is dropped even if in_ready is high.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  issue handshake (in_ready = !stall)
//   RA, RB               source registers of the issuing instruction
//   RW, wr_en, is_load   destination, write enable, load flag of the issuer
//   imm_sel_in           operand B is the immediate (RB ignored)
//   flush                kill the OP- and EX-stage instructions at this edge
//   mux_sel_A/B          registered operand selects: 00 RF, 01 ans_ex,
//                        10 ans_dm, 11 ans_wb
//   imm_sel              registered copy of imm_sel_in
//   RW_dm, wr_dm         register-file write address / enable (DM stage)
//   stall_cnt            saturating count of load-use stall cycles
//
// The WB stage carries no tag: nothing reads it. A result in WB at issue time
// has already been written back, and the instruction that is in DM before the
// issue edge (the one that will be in WB) is covered by the DM tag.
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [4:0]       RW,
  input  logic             wr_en,
  input  logic             is_load,
  input  logic             imm_sel_in,
  input  logic             flush,
  output logic [1:0]       mux_sel_A,
  output logic [1:0]       mux_sel_B,
  output logic             imm_sel,
  output logic [4:0]       RW_dm,
  output logic             wr_dm,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  // Stage tags. Only OP needs the load flag: a load is a hazard only while it
  // is one stage ahead of its consumer.
  logic       r_op_v, r_op_we, r_op_ld;
  logic [4:0] r_op_rw;
  logic       r_ex_v, r_ex_we;
  logic [4:0] r_ex_rw;
  logic       r_dm_v, r_dm_we;
  logic [4:0] r_dm_rw;

  logic [1:0]       r_sel_a;
  logic [1:0]       r_sel_b;
  logic             r_imm_sel;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_op_prod, w_ex_prod, w_dm_prod;
  logic       w_ld_hit_a, w_ld_hit_b;
  logic       w_stall;
  logic       w_take;
  logic       w_issue;
  logic [1:0] w_sel_a_nxt, w_sel_b_nxt;
  logic       w_cnt_max;

  // Youngest producer wins: the OP-stage instruction will sit in EX when the
  // consumer reaches OP, the EX one in DM, the DM one in WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       op_prod, input logic [4:0] op_rw,
    input logic       ex_prod, input logic [4:0] ex_rw,
    input logic       dm_prod, input logic [4:0] dm_rw
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (src != 5'd0) begin
      if (op_prod && (op_rw == src))      sel = SEL_EX;
      else if (ex_prod && (ex_rw == src)) sel = SEL_DM;
      else if (dm_prod && (dm_rw == src)) sel = SEL_WB;
    end
    return sel;
  endfunction

  // A slot produces a forwardable result only if it really writes a
  // register other than r0.
  assign w_op_prod = r_op_v && r_op_we && (r_op_rw != 5'd0);
  assign w_ex_prod = r_ex_v && r_ex_we && (r_ex_rw != 5'd0);
  assign w_dm_prod = r_dm_v && r_dm_we && (r_dm_rw != 5'd0);

  // Load-use: the load in OP cannot forward in time for an instruction
  // entering OP right behind it. RB is irrelevant when B is the immediate.
  assign w_ld_hit_a = w_op_prod && r_op_ld && (RA != 5'd0) && (RA == r_op_rw);
  assign w_ld_hit_b = w_op_prod && r_op_ld && !imm_sel_in &&
                      (RB != 5'd0) && (RB == r_op_rw);
  assign w_stall    = in_valid && (w_ld_hit_a || w_ld_hit_b);
  assign in_ready   = !w_stall;

  // w_take: handshake completes; w_issue: it also survives a flush.
  assign w_take  = in_valid && !w_stall;
  assign w_issue = w_take && !flush;

  always_comb begin
    w_sel_a_nxt = SEL_RF;
    w_sel_b_nxt = SEL_RF;
    if (w_take) begin
      w_sel_a_nxt = fwd_sel(RA, w_op_prod, r_op_rw, w_ex_prod, r_ex_rw,
                            w_dm_prod, r_dm_rw);
      if (!imm_sel_in) begin
        w_sel_b_nxt = fwd_sel(RB, w_op_prod, r_op_rw, w_ex_prod, r_ex_rw,
                              w_dm_prod, r_dm_rw);
      end
    end
  end

  assign w_cnt_max = &r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_v      <= 1'b0;
      r_op_we     <= 1'b0;
      r_op_ld     <= 1'b0;
      r_op_rw     <= 5'd0;
      r_ex_v      <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_rw     <= 5'd0;
      r_dm_v      <= 1'b0;
      r_dm_we     <= 1'b0;
      r_dm_rw     <= 5'd0;
      r_sel_a     <= SEL_RF;
      r_sel_b     <= SEL_RF;
      r_imm_sel   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // DM takes whatever EX held, or a bubble when EX is being flushed.
      r_dm_v  <= r_ex_v && !flush;
      r_dm_we <= r_ex_we;
      r_dm_rw <= r_ex_rw;
      r_ex_v  <= r_op_v && !flush;
      r_ex_we <= r_op_we;
      r_ex_rw <= r_op_rw;
      // OP takes the new instruction or a bubble (stall, flush, no issue).
      r_op_v  <= w_issue;
      r_op_we <= w_issue && wr_en;
      r_op_ld <= w_issue && is_load;
      r_op_rw <= w_issue ? RW : 5'd0;

      r_sel_a   <= w_sel_a_nxt;
      r_sel_b   <= w_sel_b_nxt;
      r_imm_sel <= imm_sel_in;

      // A stall cycle that coincides with a flush is not a lost cycle: the
      // flush would have discarded the slot anyway.
      if (w_stall && !flush && !w_cnt_max) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign mux_sel_A = r_sel_a;
  assign mux_sel_B = r_sel_b;
  assign imm_sel   = r_imm_sel;
  assign stall_cnt = r_stall_cnt;
  assign RW_dm     = r_dm_rw;
  assign wr_dm     = r_dm_v && r_dm_we && (r_dm_rw != 5'd0);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fwd_hazard_ctrl. Scenario tasks drive instructions, push the
// expected operand selects into exp_q and pop/compare them after the issue
// edge. The counter width is reduced so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       RA, RB, RW;
  logic             wr_en, is_load, imm_sel_in, flush;
  logic [1:0]       mux_sel_A, mux_sel_B;
  logic             imm_sel;
  logic [4:0]       RW_dm;
  logic             wr_dm;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .RA         (RA),
    .RB         (RB),
    .RW         (RW),
    .wr_en      (wr_en),
    .is_load    (is_load),
    .imm_sel_in (imm_sel_in),
    .flush      (flush),
    .mux_sel_A  (mux_sel_A),
    .mux_sel_B  (mux_sel_B),
    .imm_sel    (imm_sel),
    .RW_dm      (RW_dm),
    .wr_dm      (wr_dm),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic we, input logic ld,
                       input logic imm);
    in_valid   = v;
    RA         = ra;
    RB         = rb;
    RW         = rw;
    wr_en      = we;
    is_load    = ld;
    imm_sel_in = imm;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [3:0] got;
    rst   = 1'b1;
    flush = 1'b0;
    // instruction offered during reset must be dropped
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    checks++;
    if (wr_dm !== 1'b0) begin failures++; $display("FAIL reset_wr_dm got=%0b exp=0", wr_dm); end
    checks++;
    if (stall_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    got = {mux_sel_A, mux_sel_B};
    checks++;
    if (got !== 4'h0) begin failures++; $display("FAIL reset_sel got=%0h exp=0", got); end
    checks++;
    if (imm_sel !== 1'b0) begin failures++; $display("FAIL reset_imm got=%0b exp=0", imm_sel); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wr_dm !== 1'b0) begin failures++; $display("FAIL reset_discard cyc=%0d got=%0b exp=0", i, wr_dm); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_first got=%0b exp=%0b", got, exp); end
    drive(1'b1, 5'd3, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'b0101);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_sel got=%0b exp=%0b", got, exp); end
  endtask

  task automatic test_distance();
    logic [3:0] got, exp;
    logic [1:0] dist_sel [4];
    dist_sel[0] = 2'b01; dist_sel[1] = 2'b10; dist_sel[2] = 2'b11; dist_sel[3] = 2'b00;
    for (int n = 0; n < 4; n++) begin
      drain();
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b0000);
      tick();
      got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL dist%0d_prod got=%0b exp=%0b", n, got, exp); end
      for (int k = 0; k < n; k++) begin
        drive(1'b1, 5'd1, 5'd2, 5'(20 + k), 1'b1, 1'b0, 1'b0);
        exp_q.push_back(4'b0000);
        tick();
        got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL dist%0d_filler got=%0b exp=%0b", n, got, exp); end
      end
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back({dist_sel[n], 2'b00});
      tick();
      got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL dist%0d_sel got=%0b exp=%0b", n, got, exp); end
    end
    // two producers of r5: the younger one must win
    drain();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0001);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL youngest_first got=%0b exp=%0b", got, exp); end
  endtask

  task automatic test_load_use();
    logic [3:0] got, exp;
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(4'b0000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL lu_load got=%0b exp=%0b", got, exp); end
    drive(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%0b exp=0", in_ready); end
    checks++;
    if (stall_cnt !== 8'd0) begin failures++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt); end
    exp_q.push_back(4'b0000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL lu_stall_sel got=%0b exp=%0b", got, exp); end
    checks++;
    if (stall_cnt !== 8'd1) begin failures++; $display("FAIL lu_cnt_after got=%0d exp=1", stall_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_retry_ready got=%0b exp=1", in_ready); end
    exp_q.push_back(4'b1000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL lu_retry_sel got=%0b exp=%0b", got, exp); end
    checks++;
    if (stall_cnt !== 8'd1) begin failures++; $display("FAIL lu_cnt_retry got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_imm();
    logic [3:0] got, exp;
    drain();
    drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    // RB matches the load but B is the immediate: no stall, B select 00
    drive(1'b1, 5'd1, 5'd11, 5'd12, 1'b1, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL imm_no_stall got=%0b exp=1", in_ready); end
    exp_q.push_back(4'b0000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL imm_sel_b got=%0b exp=%0b", got, exp); end
    checks++;
    if (imm_sel !== 1'b1) begin failures++; $display("FAIL imm_reg_hi got=%0b exp=1", imm_sel); end
    drive(1'b1, 5'd1, 5'd11, 5'd13, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0010);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL imm_rb_dm got=%0b exp=%0b", got, exp); end
    checks++;
    if (imm_sel !== 1'b0) begin failures++; $display("FAIL imm_reg_lo got=%0b exp=0", imm_sel); end
    // RB load-use with a register B operand does stall
    drain();
    drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rb_stall got=%0b exp=0", in_ready); end
    tick();
    checks++;
    if (stall_cnt !== 8'd2) begin failures++; $display("FAIL rb_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_reg_zero();
    logic [3:0] got, exp;
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL r0_sel got=%0b exp=%0b", got, exp); end
    idle();
    tick();
    checks++;
    if (wr_dm !== 1'b0) begin failures++; $display("FAIL r0_wr_dm got=%0b exp=0", wr_dm); end
  endtask

  task automatic test_flush();
    logic [3:0] got, exp;
    int writes;
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (wr_dm !== 1'b1) begin failures++; $display("FAIL flush_dm_wr got=%0b exp=1", wr_dm); end
    checks++;
    if (RW_dm !== 5'd14) begin failures++; $display("FAIL flush_dm_rw got=%0d exp=14", RW_dm); end
    drive(1'b1, 5'd1, 5'd2, 5'd15, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
    tick();
    flush = 1'b0;
    idle();
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      if (wr_dm === 1'b1) writes++;
      tick();
    end
    checks++;
    if (writes !== 0) begin failures++; $display("FAIL flush_kill writes=%0d exp=0", writes); end
    // flush wins over a load-use stall
    drain();
    drive(1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_stall_ready got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 8'd2) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=2", stall_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_retry_ready got=%0b exp=1", in_ready); end
    exp_q.push_back(4'b0000);
    tick();
    got = {mux_sel_A, mux_sel_B}; exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL flush_killed_load got=%0b exp=%0b", got, exp); end
  endtask

  task automatic test_reset_mid_stall();
    int writes;
    drain();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rms_stall got=%0b exp=0", in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rms_ready got=%0b exp=1", in_ready); end
    checks++;
    if (stall_cnt !== 8'd0) begin failures++; $display("FAIL rms_cnt got=%0d exp=0", stall_cnt); end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      if (wr_dm === 1'b1) writes++;
      tick();
      idle();
    end
    checks++;
    if (writes !== 0) begin failures++; $display("FAIL rms_wr_dm writes=%0d exp=0", writes); end
  endtask

  task automatic test_saturation();
    int target;
    drain();
    target = (1 << CNT_W) + 2;
    for (int i = 1; i <= target; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == (1 << CNT_W) - 2) begin
        checks++;
        if (stall_cnt !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", stall_cnt); end
      end
      if (i == (1 << CNT_W) - 1) begin
        checks++;
        if (stall_cnt !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", stall_cnt); end
      end
    end
    checks++;
    if (stall_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", stall_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_imm();
    test_reg_zero();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
